// File: rtl/core_done_monitor.sv
// Reset-sequencing and completion monitor for a multi-core array: stretches core reset,
// latches per-core done writes, counts run cycles. Optional timeout: CORE_DONE_MONITOR_TIMEOUT_EN.
module core_done_monitor #(
  parameter int                    NUM_CORES      = 4,
  parameter int                    RST_STAGES     = 6,
  parameter int                    ADDR_WIDTH     = 14,
  parameter int                    DONE_MODE      = 1,
  parameter logic [ADDR_WIDTH-1:0] DONE_ADDR      = 14'h03FC,
  parameter int                    CNT_WIDTH      = 32,
  parameter int                    TIMEOUT_CYCLES = 2**24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_restart,
  input  logic [4*NUM_CORES-1:0]          i_dmem_wr_en,
  input  logic [ADDR_WIDTH*NUM_CORES-1:0] i_dmem_addr,
  output logic                            o_core_reset,
  output logic [NUM_CORES-1:0]            o_done_vec,
  output logic                            o_all_done,
  output logic                            o_timeout,
  output logic [CNT_WIDTH-1:0]            o_cycle_count,
  output logic                            o_led
);

  localparam int HW = (RST_STAGES > 1) ? $clog2(RST_STAGES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_STAGES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  if (NUM_CORES < 1 || NUM_CORES > 32 || RST_STAGES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("core_done_monitor: illegal parameter values");
  end

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t                state;
  logic [HW-1:0]         hold_cnt;
  logic [NUM_CORES-1:0]  done_ev;

  // A core reports done by writing its mailbox word (or any word when DONE_MODE is 0).
  always_comb begin
    done_ev = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      done_ev[c] = (|i_dmem_wr_en[4*c +: 4]) &&
                   ((DONE_MODE == 0) || (i_dmem_addr[ADDR_WIDTH*c +: ADDR_WIDTH] == DONE_ADDR));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_HOLD;
      hold_cnt      <= '0;
      o_core_reset  <= 1'b1;
      o_done_vec    <= '0;
      o_all_done    <= 1'b0;
      o_timeout     <= 1'b0;
      o_cycle_count <= '0;
      o_led         <= 1'b0;
    end else begin
      o_led <= o_all_done;
      if (i_restart) begin
        state         <= S_HOLD;
        hold_cnt      <= '0;
        o_core_reset  <= 1'b1;
        o_done_vec    <= '0;
        o_all_done    <= 1'b0;
        o_timeout     <= 1'b0;
        o_cycle_count <= '0;
      end else begin
        case (state)
          S_HOLD: begin
            o_core_reset <= 1'b1;
            if (hold_cnt == HOLD_LAST) begin
              state        <= S_RUN;
              hold_cnt     <= '0;
              o_core_reset <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          S_RUN: begin
            o_done_vec <= o_done_vec | done_ev;
            // All-done is tested first so it wins over a coincident timeout.
            if (&o_done_vec) begin
              state      <= S_DONE;
              o_all_done <= 1'b1;
            end
`ifdef CORE_DONE_MONITOR_TIMEOUT_EN
            else if (o_cycle_count == TIMEOUT_LAST) begin
              state     <= S_TIMEOUT;
              o_timeout <= 1'b1;
            end
`endif
            else if (o_cycle_count != '1) begin
              o_cycle_count <= o_cycle_count + CNT_WIDTH'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_done_monitor.sv
// Randomized bench for core_done_monitor: two instances (mailbox mode and any-write mode)
// checked every cycle against an edge-counting behavioural model plus directed literal checks.
module tb_core_done_monitor;

  localparam int NC   = 4;
  localparam int RST  = 6;
  localparam int AW   = 14;
  localparam int CW   = 32;
  localparam int TO   = 100;
  localparam logic [AW-1:0] MBOX = 14'h03FC;
  localparam longint CNT_MAX = (longint'(1) << CW) - 1;
`ifdef CORE_DONE_MONITOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              restart = 1'b0;
  logic [4*NC-1:0]   wr = '0;
  logic [AW*NC-1:0]  addr = '0;

  logic              cr   [2];
  logic [NC-1:0]     vec  [2];
  logic              alld [2];
  logic              tmo  [2];
  logic [CW-1:0]     cnt  [2];
  logic              led  [2];

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  core_done_monitor #(.NUM_CORES(NC), .RST_STAGES(RST), .ADDR_WIDTH(AW), .DONE_MODE(1),
    .DONE_ADDR(MBOX), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) u_dut_mbox (
    .clk(clk), .reset(reset), .i_restart(restart), .i_dmem_wr_en(wr), .i_dmem_addr(addr),
    .o_core_reset(cr[0]), .o_done_vec(vec[0]), .o_all_done(alld[0]), .o_timeout(tmo[0]),
    .o_cycle_count(cnt[0]), .o_led(led[0]));

  core_done_monitor #(.NUM_CORES(NC), .RST_STAGES(RST), .ADDR_WIDTH(AW), .DONE_MODE(0),
    .DONE_ADDR(MBOX), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) u_dut_any (
    .clk(clk), .reset(reset), .i_restart(restart), .i_dmem_wr_en(wr), .i_dmem_addr(addr),
    .o_core_reset(cr[1]), .o_done_vec(vec[1]), .o_all_done(alld[1]), .o_timeout(tmo[1]),
    .o_cycle_count(cnt[1]), .o_led(led[1]));

  // Model: index 0 = mailbox mode, index 1 = any-write mode.
  // "since" counts edges since reset/restart; the cores are held while since < RST.
  int            since [2] = '{0, 0};
  logic [NC-1:0] m_vec [2] = '{'0, '0};
  longint        m_cnt [2] = '{0, 0};
  bit            m_all [2] = '{0, 0};
  bit            m_to  [2] = '{0, 0};
  bit            m_led [2] = '{0, 0};

  function automatic logic [NC-1:0] events(int any_write);
    logic [NC-1:0] e = '0;
    for (int c = 0; c < NC; c++)
      e[c] = (wr[4*c +: 4] != 4'd0) && (any_write != 0 || addr[AW*c +: AW] == MBOX);
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        since[m] <= 0; m_vec[m] <= '0; m_cnt[m] <= 0;
        m_all[m] <= 1'b0; m_to[m] <= 1'b0; m_led[m] <= 1'b0;
      end else begin
        m_led[m] <= m_all[m];
        if (restart) begin
          since[m] <= 0; m_vec[m] <= '0; m_cnt[m] <= 0;
          m_all[m] <= 1'b0; m_to[m] <= 1'b0;
        end else if (since[m] < RST) begin
          since[m] <= since[m] + 1;
        end else if (!m_all[m] && !m_to[m]) begin
          m_vec[m] <= m_vec[m] | events(m);
          if (m_vec[m] == '1)                   m_all[m] <= 1'b1;
          else if (TO_EN && m_cnt[m] == TO - 1) m_to[m]  <= 1'b1;
          else if (m_cnt[m] < CNT_MAX)          m_cnt[m] <= m_cnt[m] + 1;
        end
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("dut%0d.core_reset", m), 64'(cr[m]), 64'(since[m] < RST));
        check($sformatf("dut%0d.done_vec", m), 64'(vec[m]), 64'(m_vec[m]));
        check($sformatf("dut%0d.all_done", m), 64'(alld[m]), 64'(m_all[m]));
        check($sformatf("dut%0d.timeout", m), 64'(tmo[m]), 64'(m_to[m]));
        check($sformatf("dut%0d.cycle_count", m), 64'(cnt[m]), 64'(m_cnt[m]));
        check($sformatf("dut%0d.led", m), 64'(led[m]), 64'(m_led[m]));
      end
    end
  end

  // Presents one write for core c for a single edge, returns on the following negedge.
  task automatic write_core(int c, logic [AW-1:0] a);
    wr = '0;
    wr[4*c +: 4] = 4'($urandom_range(1, 15));
    addr[AW*c +: AW] = a;
    @(negedge clk);
    wr = '0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic wait_hold();
    int n = 0;
    while ((since[0] < RST || since[1] < RST) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_hold_bound", 64'(n < 20), 64'(1));
  endtask

  initial begin
    #1 checking = 1'b1;
    repeat (3) @(negedge clk);
    check("lit_reset_core_reset", 64'(cr[0]), 64'(1));
    check("lit_reset_count", 64'(cnt[0]), 64'(0));
    check("lit_reset_led", 64'(led[0]), 64'(0));

    // Release reset with every core writing the mailbox during HOLD.
    reset = 1'b0;
    wr = '1;
    for (int c = 0; c < NC; c++) addr[AW*c +: AW] = MBOX;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) wr = '0;
      check("lit_hold_core_reset", 64'(cr[0]), 64'(k < 6));
      check("lit_hold_vec_mbox", 64'(vec[0]), 64'(0));
      check("lit_hold_vec_any", 64'(vec[1]), 64'(0));
    end

    write_core(0, MBOX);
    write_core(2, MBOX);
    write_core(1, MBOX);
    write_core(3, 14'h0100);
    @(negedge clk);
    check("lit_partial_vec", 64'(vec[0]), 64'(4'b0111));
    check("lit_partial_all", 64'(alld[0]), 64'(0));
    check("lit_any_vec", 64'(vec[1]), 64'(4'hF));
    write_core(3, MBOX);
    check("lit_full_vec", 64'(vec[0]), 64'(4'hF));
    check("lit_full_all_pre", 64'(alld[0]), 64'(0));
    @(negedge clk);
    check("lit_all_done", 64'(alld[0]), 64'(1));
    check("lit_led_pre", 64'(led[0]), 64'(0));
    check("lit_count_frozen_a", 64'(cnt[0]), 64'(6));
    repeat (3) @(negedge clk);
    check("lit_led", 64'(led[0]), 64'(1));
    check("lit_count_frozen_b", 64'(cnt[0]), 64'(6));

    // Restart from DONE, then a full hold sequence again.
    pulse_restart();
    check("lit_rst_core_reset", 64'(cr[0]), 64'(1));
    check("lit_rst_vec", 64'(vec[0]), 64'(0));
    check("lit_rst_all", 64'(alld[0]), 64'(0));
    check("lit_rst_count", 64'(cnt[0]), 64'(0));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("lit_rehold_core_reset", 64'(cr[0]), 64'(k < 6));
    end

    // Asynchronous reset in the middle of RUN.
    write_core(0, MBOX);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("lit_async_core_reset", 64'(cr[0]), 64'(1));
    check("lit_async_vec", 64'(vec[0]), 64'(0));
    check("lit_async_count", 64'(cnt[0]), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    wait_hold();

    // Only core 0 finishes: the run either times out at 99 or keeps counting.
    write_core(0, MBOX);
    repeat (110) @(negedge clk);
`ifdef CORE_DONE_MONITOR_TIMEOUT_EN
    check("lit_timeout", 64'(tmo[0]), 64'(1));
    check("lit_timeout_count", 64'(cnt[0]), 64'(99));
`else
    check("lit_no_timeout", 64'(tmo[0]), 64'(0));
    check("lit_no_timeout_count", 64'(cnt[0]), 64'(111));
`endif

    // Last done event timed so all-done coincides with the timeout edge.
    pulse_restart();
    wait_hold();
    write_core(0, MBOX);
    write_core(1, MBOX);
    write_core(2, MBOX);
    begin
      int n = 0;
      while (m_cnt[0] != 98 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("wait_cnt98_bound", 64'(n < 200), 64'(1));
    end
    write_core(3, MBOX);
    @(negedge clk);
    check("lit_coincide_all", 64'(alld[0]), 64'(1));
    check("lit_coincide_timeout", 64'(tmo[0]), 64'(0));
    check("lit_coincide_count", 64'(cnt[0]), 64'(99));

    // Random traffic with occasional restarts and asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      restart = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < NC; c++) begin
        wr[4*c +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        addr[AW*c +: AW] = ($urandom_range(0, 1) == 1) ? MBOX : AW'($urandom_range(0, 16383));
      end
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    restart = 1'b0;
    wr = '0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_done_monitor.md
# core_done_monitor

Parametrised reset-sequencing and completion monitor for multi-core BRISKI builds. It stretches the core reset for a configurable number of cycles and watches each core's data-memory write port for a "done" write. It records a sticky per-core done flag, counts run cycles, and raises an all-done (or timeout) status for the board LED. It sits in the top-level wrapper between the reset synchronizer and the RISC-V core array / BRAMs.

## Interface
Parameters:
- `NUM_CORES`, 4: number of monitored cores (1..32).
- `RST_STAGES`, 6: cycles `o_core_reset` is held after reset release or restart (≥1).
- `ADDR_WIDTH`, 14: width of each core's dmem address.
- `DONE_MODE`, 1: 0 = any write is a done event; 1 = only a write to `DONE_ADDR` is a done event.
- `DONE_ADDR`, 14'h03FC: done-mailbox word address, used when `DONE_MODE`=1.
- `CNT_WIDTH`, 32: width of the run-cycle counter.
- `TIMEOUT_CYCLES`, 2**24: run-cycle limit; used only with the timeout feature.

Ports:
- `clk`  in  1  core clock (MMCM output).
- `reset`  in  1  asynchronous, active-high reset.
- `i_restart`  in  1  synchronous single-cycle restart request.
- `i_dmem_wr_en`  in  4*NUM_CORES  byte write enables; core c owns bits [4c+3:4c].
- `i_dmem_addr`  in  ADDR_WIDTH*NUM_CORES  dmem addresses; core c owns slice c.
- `o_core_reset`  out  1  synchronous reset to cores.
- `o_done_vec`  out  NUM_CORES  sticky per-core done flags.
- `o_all_done`  out  1  all cores done.
- `o_timeout`  out  1  run limit reached before all-done.
- `o_cycle_count`  out  CNT_WIDTH  cycles spent in RUN.
- `o_led`  out  1  registered LED drive.

## Operation
- States: HOLD, RUN, DONE, TIMEOUT. Encoding is free.
- Reset values: state=HOLD, hold counter=0, `o_core_reset`=1, `o_done_vec`=0, `o_all_done`=0, `o_timeout`=0, `o_cycle_count`=0, `o_led`=0.
- HOLD:
  - `o_core_reset`=1 and the hold counter increments.
  - At count RST_STAGES-1, the next state is RUN.
  - Done events are ignored.
- Done event for core c: `|i_dmem_wr_en[4c+3:4c]`, AND (`DONE_MODE`=0 or `i_dmem_addr` slice c == `DONE_ADDR`).
- RUN:
  - `o_core_reset`=0.
  - `o_cycle_count` increments each cycle and saturates at all-ones.
  - A done event sets `o_done_vec[c]` at the next edge. Flags stay set until reset or restart.
- RUN→DONE on the edge where `&o_done_vec`=1. `o_all_done`=1 while in DONE. `o_cycle_count` freezes.
- RUN→TIMEOUT when `o_cycle_count`==TIMEOUT_CYCLES-1 and not all done. `o_timeout`=1 and the count freezes.
- Simultaneous all-done and timeout on the same edge: DONE wins.
- DONE and TIMEOUT are terminal. Events there do not change `o_done_vec`.
- `i_restart`:
  - In RUN, DONE or TIMEOUT: go to HOLD; clear the hold counter, `o_done_vec`, `o_cycle_count`, `o_all_done` and `o_timeout`.
  - In HOLD: restart the hold counter.
- `o_led` <= `o_all_done` (one-cycle registered copy).

## Timing
- After `reset` deasserts, `o_core_reset` stays 1 for exactly RST_STAGES rising edges. It is 0 after edge RST_STAGES.
- The first RUN cycle has `o_cycle_count`=0.
- Done event at edge N: `o_done_vec[c]`=1 after edge N+1. If that completes the vector, `o_all_done`=1 after edge N+2 and `o_led`=1 after edge N+3.
- Restart at edge N:
  - `o_core_reset`=1 and all status bits are cleared after edge N+1.
  - Hold then lasts RST_STAGES edges.
- `reset` asynchronously forces reset values mid-operation. All outputs are registered.

## Configuration
- `CORE_DONE_MONITOR_TIMEOUT_EN` defined:
  - TIMEOUT state and `TIMEOUT_CYCLES` comparison are compiled in.
- Not defined:
  - No TIMEOUT state; `o_timeout` is constant 0.
  - RUN waits indefinitely for all-done, and `o_cycle_count` saturates.

## Test plan
- Reset release, RST_STAGES=6 → `o_core_reset` high for 6 edges, then low; all other outputs 0.
- NUM_CORES=4, DONE_MODE=1: cores 0,2,1 write 0x03FC; core 3 writes 0x0100 → `o_done_vec`=4'b0111, no all-done. Core 3 then writes 0x03FC → `o_done_vec`=4'hF, `o_all_done` next cycle, `o_led` one cycle later, `o_cycle_count` frozen.
- DONE_MODE=0: a single byte write (wr_en=4'b0001) by each core → all-done. Writes during HOLD → `o_done_vec` stays 0.
- With macro, TIMEOUT_CYCLES=100, only core 0 done → `o_timeout`=1 with `o_cycle_count`=99. Last done event timed to coincide → DONE, `o_timeout`=0.
- `i_restart` pulse in DONE → flags/count cleared, 6-cycle `o_core_reset`, run repeats. Asynchronous `reset` mid-RUN → immediate reset values.
